// File: rtl/zynq_pl_arb_pkg.sv
// Shared types and width helpers for the PL-to-PS packet arbiter and its
// rotating-priority picker.
package zynq_pl_arb_pkg;

    // IDLE: picking a new packet; LOCK: a multi-word packet owns the FIFO.
    typedef enum logic {
        e_idle = 1'b0,
        e_lock = 1'b1
    } arb_state_e;

    // Index width for a requester count; never below 1 so ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a packed per-requester bus.
    function automatic int flat_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/zynq_rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   req_i        request vector
//   last_grant_i most recent grantee; it becomes lowest priority
//   pick_o       first requester found scanning upward from last_grant_i+1
//   any_v_o      at least one request is present
module zynq_rr_pick
    import zynq_pl_arb_pkg::*;
#(
    parameter  int num_req_p = 2,
    localparam int idx_w_lp  = idx_width(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [idx_w_lp-1:0]  last_grant_i,
    output logic [idx_w_lp-1:0]  pick_o,
    output logic                 any_v_o
);

    // One spare bit so last_grant + offset cannot overflow before the wrap.
    logic [idx_w_lp:0] idx;

    always_comb begin
        pick_o  = '0;
        any_v_o = |req_i;
        idx     = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int off = num_req_p; off >= 1; off--) begin
            idx = {1'b0, last_grant_i} + (idx_w_lp+1)'(off);
            if (idx >= (idx_w_lp+1)'(num_req_p))
                idx = idx - (idx_w_lp+1)'(num_req_p);
            if (req_i[idx[idx_w_lp-1:0]])
                pick_o = idx[idx_w_lp-1:0];
        end
    end

endmodule

// File: rtl/zynq_pl_to_ps_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of the shell's PL-to-PS FIFO.
// A packet of len+1 words, once started, owns the FIFO until its last word
// so messages never interleave. Per-requester completed-packet counters are
// exported for PS-side debug.
// Ports:
//   aclk, aresetn          clock, async active-low reset
//   req_data_i/len_i/v_i   packed per-requester word, length-1, valid
//   req_yumi_o             one-hot (or zero) word-consumed strobe
//   data_o, v_o, ready_i   FIFO side, handshake = v_o & ready_i
//   busy_o                 mid-packet (LOCK)
//   pkt_cnt_o              packed completed-packet counters
module zynq_pl_to_ps_packet_arbiter
    import zynq_pl_arb_pkg::*;
#(
    parameter int num_req_p    = 2,
    parameter int data_width_p = 32,
    parameter int len_width_p  = 4,
    parameter int cnt_width_p  = 32
) (
    input  logic                                       aclk,
    input  logic                                       aresetn,
    input  logic [flat_width(num_req_p,data_width_p)-1:0] req_data_i,
    input  logic [flat_width(num_req_p,len_width_p)-1:0]  req_len_i,
    input  logic [num_req_p-1:0]                       req_v_i,
    output logic [num_req_p-1:0]                       req_yumi_o,
    output logic [data_width_p-1:0]                    data_o,
    output logic                                       v_o,
    input  logic                                       ready_i,
    output logic                                       busy_o,
    output logic [flat_width(num_req_p,cnt_width_p)-1:0]  pkt_cnt_o
);

    localparam int idx_w_lp = idx_width(num_req_p);

    logic [num_req_p-1:0][data_width_p-1:0] req_data;
    logic [num_req_p-1:0][len_width_p-1:0]  req_len;
    assign req_data = req_data_i;
    assign req_len  = req_len_i;

    arb_state_e            state_q,      state_n;
    logic [idx_w_lp-1:0]    owner_q,      owner_n;
    logic [len_width_p-1:0] remain_q,     remain_n;
    logic [idx_w_lp-1:0]    last_grant_q, last_grant_n;
    logic [num_req_p-1:0]   cnt_inc;

    logic [idx_w_lp-1:0] pick;
    logic                any_v;
    logic                sel_v;
    logic [data_width_p-1:0] sel_data;
    logic                hs;

    zynq_rr_pick #(.num_req_p(num_req_p)) u_pick (
        .req_i        (req_v_i),
        .last_grant_i (last_grant_q),
        .pick_o       (pick),
        .any_v_o      (any_v)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= e_idle;
            owner_q      <= '0;
            remain_q     <= '0;
            last_grant_q <= idx_w_lp'(num_req_p - 1);
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            remain_q     <= remain_n;
            last_grant_q <= last_grant_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        remain_n     = remain_q;
        last_grant_n = last_grant_q;
        cnt_inc      = '0;
        req_yumi_o   = '0;
        sel_v        = 1'b0;
        sel_data     = '0;
        hs           = 1'b0;

        if (state_q == e_idle) begin
            sel_v    = any_v;
            sel_data = req_data[pick];
            hs       = sel_v & ready_i;
            req_yumi_o[pick] = hs;
            if (hs) begin
                if (req_len[pick] == '0) begin
                    last_grant_n  = pick;
                    cnt_inc[pick] = 1'b1;
                end else begin
                    // Rotation pointer moves only when the packet finishes.
                    state_n  = e_lock;
                    owner_n  = pick;
                    remain_n = req_len[pick];
                end
            end
        end else begin
            sel_v    = req_v_i[owner_q];
            sel_data = req_data[owner_q];
            hs       = sel_v & ready_i;
            req_yumi_o[owner_q] = hs;
            if (hs) begin
                remain_n = remain_q - len_width_p'(1);
                if (remain_q == len_width_p'(1)) begin
                    state_n          = e_idle;
                    last_grant_n     = owner_q;
                    cnt_inc[owner_q] = 1'b1;
                end
            end
        end

        // Nothing is offered while reset is held, whatever the producers show.
        if (!aresetn) begin
            sel_v      = 1'b0;
            req_yumi_o = '0;
        end
    end

    assign v_o    = sel_v;
    assign data_o = sel_v ? sel_data : '0;
    assign busy_o = (state_q == e_lock);

    for (genvar i = 0; i < num_req_p; i++) begin : g_cnt
        logic [cnt_width_p-1:0] cnt_r;
        // Only written on increment; wraps silently.
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn)
                cnt_r <= '0;
            else if (cnt_inc[i])
                cnt_r <= cnt_r + cnt_width_p'(1);
        end
        assign pkt_cnt_o[i*cnt_width_p +: cnt_width_p] = cnt_r;
    end

endmodule

// File: tb/tb_zynq_pl_to_ps_packet_arbiter.sv
module tb_zynq_pl_to_ps_packet_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [63:0] req_data_i;
    logic [7:0]  req_len_i;
    logic [1:0]  req_v_i;
    logic [1:0]  req_yumi_o;
    logic [31:0] data_o;
    logic        v_o;
    logic        ready_i;
    logic        busy_o;
    logic [63:0] pkt_cnt_o;

    int checks   = 0;
    int failures = 0;
    int hs_cnt;

    always #5 aclk = ~aclk;

    zynq_pl_to_ps_packet_arbiter dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .req_data_i (req_data_i),
        .req_len_i  (req_len_i),
        .req_v_i    (req_v_i),
        .req_yumi_o (req_yumi_o),
        .data_o     (data_o),
        .v_o        (v_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o),
        .pkt_cnt_o  (pkt_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [31:0] d0, input logic [3:0] l0,
                           input logic [31:0] d1, input logic [3:0] l1);
        req_v_i    = v;
        req_data_i = {d1, d0};
        req_len_i  = {l1, l0};
    endtask

    // Check the combinational outputs mid-cycle, then advance past the edge.
    task automatic step(input string tag, input logic [1:0] e_yumi, input logic e_v,
                        input logic [31:0] e_data, input logic e_busy);
        @(negedge aclk);
        chk({tag, ".yumi"}, {62'd0, req_yumi_o}, {62'd0, e_yumi});
        chk({tag, ".v"},    {63'd0, v_o},        {63'd0, e_v});
        chk({tag, ".data"}, {32'd0, data_o},     {32'd0, e_data});
        chk({tag, ".busy"}, {63'd0, busy_o},     {63'd0, e_busy});
        if (req_yumi_o != 2'b00) hs_cnt++;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        aresetn = 1'b0;
        ready_i = 1'b0;
        set_req(2'b00, 32'h0, 4'd0, 32'h0, 4'd0);
        #3;
        chk("rst.v",    {63'd0, v_o},        64'd0);
        chk("rst.yumi", {62'd0, req_yumi_o}, 64'd0);
        chk("rst.busy", {63'd0, busy_o},     64'd0);
        chk("rst.data", {32'd0, data_o},     64'd0);
        chk("rst.cnt",  pkt_cnt_o,           64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // 1: single-word packets alternate starting with requester 0
        ready_i = 1'b1;
        set_req(2'b11, 32'h000000A0, 4'd0, 32'h000000B0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) step("t1", 2'b01, 1'b1, 32'h000000A0, 1'b0);
            else            step("t1", 2'b10, 1'b1, 32'h000000B0, 1'b0);
        end
        chk("t1.cnt0", {32'd0, pkt_cnt_o[31:0]},  64'd2);
        chk("t1.cnt1", {32'd0, pkt_cnt_o[63:32]}, 64'd2);

        // 2: 4-word packet from req0 is not interleaved with req1
        set_req(2'b11, 32'h000000A0, 4'd3, 32'h000000B0, 4'd0);
        step("t2.w0", 2'b01, 1'b1, 32'h000000A0, 1'b0);
        set_req(2'b11, 32'h000000A1, 4'd3, 32'h000000B0, 4'd0);
        step("t2.w1", 2'b01, 1'b1, 32'h000000A1, 1'b1);
        set_req(2'b11, 32'h000000A2, 4'd3, 32'h000000B0, 4'd0);
        step("t2.w2", 2'b01, 1'b1, 32'h000000A2, 1'b1);
        set_req(2'b11, 32'h000000A3, 4'd3, 32'h000000B0, 4'd0);
        step("t2.w3", 2'b01, 1'b1, 32'h000000A3, 1'b1);
        set_req(2'b10, 32'h0, 4'd0, 32'h000000B0, 4'd0);
        step("t2.b0", 2'b10, 1'b1, 32'h000000B0, 1'b0);
        chk("t2.cnt", pkt_cnt_o, {32'd3, 32'd3});

        // 3: ready toggling inside a 3-word packet
        hs_cnt = 0;
        set_req(2'b01, 32'h000000C0, 4'd2, 32'h0, 4'd0);
        ready_i = 1'b1;
        step("t3.c0", 2'b01, 1'b1, 32'h000000C0, 1'b0);
        set_req(2'b01, 32'h000000C1, 4'd0, 32'h0, 4'd0);
        ready_i = 1'b0;
        step("t3.hold1", 2'b00, 1'b1, 32'h000000C1, 1'b1);
        ready_i = 1'b1;
        step("t3.c1", 2'b01, 1'b1, 32'h000000C1, 1'b1);
        set_req(2'b01, 32'h000000C2, 4'd0, 32'h0, 4'd0);
        ready_i = 1'b0;
        step("t3.hold2", 2'b00, 1'b1, 32'h000000C2, 1'b1);
        ready_i = 1'b1;
        step("t3.c2", 2'b01, 1'b1, 32'h000000C2, 1'b1);
        set_req(2'b00, 32'h0, 4'd0, 32'h0, 4'd0);
        step("t3.idle", 2'b00, 1'b0, 32'h0, 1'b0);
        chk("t3.hs", 64'(hs_cnt), 64'd3);
        chk("t3.cnt", pkt_cnt_o, {32'd3, 32'd4});

        // 4: owner stalls mid-packet while req1 waits
        set_req(2'b01, 32'h000000D0, 4'd2, 32'h000000B1, 4'd0);
        step("t4.d0", 2'b01, 1'b1, 32'h000000D0, 1'b0);
        set_req(2'b11, 32'h000000D1, 4'd0, 32'h000000B1, 4'd0);
        step("t4.d1", 2'b01, 1'b1, 32'h000000D1, 1'b1);
        set_req(2'b10, 32'h0, 4'd0, 32'h000000B1, 4'd0);
        for (int k = 0; k < 5; k++)
            step("t4.stall", 2'b00, 1'b0, 32'h0, 1'b1);
        set_req(2'b11, 32'h000000D2, 4'd0, 32'h000000B1, 4'd0);
        step("t4.d2", 2'b01, 1'b1, 32'h000000D2, 1'b1);
        set_req(2'b10, 32'h0, 4'd0, 32'h000000B1, 4'd0);
        step("t4.b1", 2'b10, 1'b1, 32'h000000B1, 1'b0);
        chk("t4.cnt", pkt_cnt_o, {32'd4, 32'd5});

        // 5: async reset while locked with remain=2
        set_req(2'b01, 32'h000000E0, 4'd2, 32'h0, 4'd0);
        step("t5.e0", 2'b01, 1'b1, 32'h000000E0, 1'b0);
        set_req(2'b01, 32'h000000E1, 4'd0, 32'h0, 4'd0);
        ready_i = 1'b0;
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        chk("t5.v",    {63'd0, v_o},        64'd0);
        chk("t5.busy", {63'd0, busy_o},     64'd0);
        chk("t5.yumi", {62'd0, req_yumi_o}, 64'd0);
        chk("t5.cnt",  pkt_cnt_o,           64'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        ready_i = 1'b1;
        set_req(2'b11, 32'h000000E5, 4'd0, 32'h000000B5, 4'd0);
        step("t5.post", 2'b01, 1'b1, 32'h000000E5, 1'b0);
        set_req(2'b00, 32'h0, 4'd0, 32'h0, 4'd0);

        // 6: counter wrap on requester 1
        @(negedge aclk);
        force dut.g_cnt[1].cnt_r = 32'hFFFFFFFF;
        #1;
        release dut.g_cnt[1].cnt_r;
        #1;
        chk("t6.pre", {32'd0, pkt_cnt_o[63:32]}, 64'h00000000FFFFFFFF);
        @(posedge aclk);
        #1;
        set_req(2'b10, 32'h0, 4'd0, 32'h000000F0, 4'd0);
        step("t6.f0", 2'b10, 1'b1, 32'h000000F0, 1'b0);
        set_req(2'b00, 32'h0, 4'd0, 32'h0, 4'd0);
        @(negedge aclk);
        chk("t6.cnt1", {32'd0, pkt_cnt_o[63:32]}, 64'd0);
        chk("t6.cnt0", {32'd0, pkt_cnt_o[31:0]},  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zynq_pl_to_ps_packet_arbiter.md
Name: zynq_pl_to_ps_packet_arbiter

Overview:
Shares the single PL-to-PS FIFO of the Zynq PL shell among several PL-side producers, such as the BlackParrot I/O decoder and debug/trace sources. Selection is round-robin at packet granularity, so multi-word messages never interleave in the PS-visible FIFO. It sits between the producers and the shell's pl_to_ps_fifo data/v/ready port. It also keeps per-requester packet counters for PS-side debug via the shell's pl-to-ps CSRs.

Parameters:
num_req_p, 2, number of producers; must be ≥2.
data_width_p, 32, word width; equals the shell's AXI-lite data width.
len_width_p, 4, width of the per-packet length field (packet = len+1 words, max 16).
cnt_width_p, 32, width of each packet counter.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset; asynchronous, active-low.
req_data_i  in  num_req_p*data_width_p  per-requester word, packed, requester 0 in LSBs.
req_len_i  in  num_req_p*len_width_p  words-minus-one; meaningful only with the first word of a packet.
req_v_i  in  num_req_p  per-requester word valid.
req_yumi_o  out  num_req_p  word consumed this cycle; one-hot or zero.
data_o  out  data_width_p  word to the FIFO.
v_o  out  1  word valid to the FIFO.
ready_i  in  1  FIFO ready; handshake = v_o & ready_i.
busy_o  out  1  a packet is mid-transfer (LOCK state).
pkt_cnt_o  out  num_req_p*cnt_width_p  completed packets per requester.

Behaviour:
- States: IDLE, LOCK. Registers:
  - state
  - owner (clog2 num_req_p bits)
  - remain (len_width_p bits)
  - last_grant pointer
  - pkt_cnt array
- Async reset (aresetn=0) values:
  - state=IDLE, owner=0, remain=0
  - last_grant=num_req_p-1, so requester 0 has first priority
  - all pkt_cnt=0
  - Consequently v_o=0, req_yumi_o=0, busy_o=0, data_o=0.
- IDLE:
  - Combinational pick: the first i with req_v_i[i]=1, scanning from last_grant+1 with wrap-around.
  - v_o = |req_v_i. data_o = picked requester's data.
  - req_yumi_o[pick] = v_o & ready_i.
  - First word passes with zero latency.
- IDLE handshake with picked len=0:
  - Stay IDLE.
  - last_grant ← pick.
  - pkt_cnt[pick]++.
- IDLE handshake with len>0:
  - Go to LOCK.
  - owner ← pick, remain ← len.
  - last_grant unchanged until the packet ends.
- IDLE, no handshake (ready_i=0): no state change. The pick may change next cycle if inputs change; producers must hold v/data/len until yumi.
- LOCK:
  - v_o = req_v_i[owner]. data_o = req_data_i[owner].
  - Other requesters are never yumi'd.
  - Each handshake: remain--.
  - Handshake with remain=1: go to IDLE, last_grant ← owner, pkt_cnt[owner]++.
  - req_len_i is ignored in LOCK.
- Owner dropping v mid-packet: v_o=0 and the block waits indefinitely. There is no timeout and no preemption.
- Fairness: a requester that just completed a packet has lowest priority next. With all requesters continuously valid, grants rotate 0,1,…,num_req_p-1,0.
- Counter overflow: pkt_cnt wraps from 2^cnt_width_p-1 to 0 silently.
- busy_o = (state==LOCK).
- Reset mid-packet: immediate return to IDLE. The partial packet is abandoned; the FIFO/PS side is reset by the same aresetn.
- The FIFO handshake is ready/valid. v_o never depends on ready_i.

Decomposition:
- Shared package zynq_pl_arb_pkg holds:
  - state enum (e_idle, e_lock)
  - packed-array width helper constants
- One natural sub-module: zynq_rr_pick, a combinational rotating-priority picker.
  - Inputs: req vector, last_grant.
  - Outputs: pick index, any_v.
  - Reusable for other shared PL resources.
- Counters and FSM live in the top.

Test Plan:
1. Single-word packets, req0 and req1 both valid with len=0, ready_i=1 every cycle → yumi alternates 0,1,0,1 starting with 0 after reset; pkt_cnt = {2,2} after 4 cycles.
2. req0 len=3 (data A0..A3) and req1 len=0 (B0) asserted together → FIFO sees A0,A1,A2,A3,B0 with no interleave; busy_o high for the cycles after A0 through A3.
3. LOCK with ready_i toggling 1,0,1,0 and owner len=2 → exactly 3 handshakes; remain goes 2→1→IDLE; data_o held stable while ready_i=0.
4. Owner deasserts v for 5 cycles mid-packet while req1 is valid → v_o=0 and req_yumi_o=0 for those 5 cycles; the packet then completes before req1 is granted.
5. Assert aresetn=0 asynchronously mid-LOCK (remain=2) → same-instant v_o=0, busy_o=0, pkt_cnt=0. After release, requester 0 wins if both are valid.
6. Preload pkt_cnt[1] to 32'hFFFFFFFF via a bench force, then complete one req1 packet → pkt_cnt[1]=0 and pkt_cnt[0] unchanged.
